// File: rtl/fpnew_pipe_out.sv
// ---------------------------------------------------------------------------
// fpnew_pipe_out : elastic output register pipeline with sticky flag accumulator
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fpnew_pkg;
  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;
endpackage

module fpnew_pipe_out #(
  parameter int  Width       = 32,
  parameter int  NumPipeRegs = 0,
  parameter type TagType     = logic,
  parameter type AuxType     = logic,
  localparam int OccWidth    = ($clog2(NumPipeRegs + 1) > 1) ? $clog2(NumPipeRegs + 1) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [Width-1:0]    result_i,
  input  fpnew_pkg::status_t  status_i,
  input  logic                extension_bit_i,
  input  TagType              tag_i,
  input  AuxType              aux_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  input  logic                clr_fflags_i,
  output logic [Width-1:0]    result_o,
  output fpnew_pkg::status_t  status_o,
  output logic                extension_bit_o,
  output TagType              tag_o,
  output AuxType              aux_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output fpnew_pkg::status_t  fflags_o,
  output logic [OccWidth-1:0] occupancy_o,
  output logic                busy_o
);

  logic [Width-1:0]   w_result [0:NumPipeRegs];
  fpnew_pkg::status_t w_status [0:NumPipeRegs];
  logic               w_ext    [0:NumPipeRegs];
  TagType             w_tag    [0:NumPipeRegs];
  AuxType             w_aux    [0:NumPipeRegs];
  logic [NumPipeRegs:0] w_valid;
  logic [NumPipeRegs:0] w_ready;
  logic [OccWidth-1:0]  w_occ;
  logic                 w_out_hs;
  fpnew_pkg::status_t   r_fflags;

  assign w_result[0] = result_i;
  assign w_status[0] = status_i;
  assign w_ext[0]    = extension_bit_i;
  assign w_tag[0]    = tag_i;
  assign w_aux[0]    = aux_i;
  assign w_valid[0]  = in_valid_i;

  // A stage may accept when the next one drains or is empty, so bubbles collapse.
  always_comb begin
    w_ready = '0;
    w_ready[NumPipeRegs] = out_ready_i;
    for (int i = NumPipeRegs - 1; i >= 0; i--) begin
      w_ready[i] = w_ready[i+1] | ~w_valid[i+1];
    end
  end

  for (genvar i = 0; i < NumPipeRegs; i++) begin : g_stage
    logic               r_valid;
    logic [Width-1:0]   r_result;
    fpnew_pkg::status_t r_status;
    logic               r_ext;
    TagType             r_tag;
    AuxType             r_aux;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_valid <= 1'b0;
      end else if (flush_i) begin
        r_valid <= 1'b0;
      end else if (w_ready[i]) begin
        r_valid <= w_valid[i];
      end
    end

    // Data only moves with a real item, so a bubble never clobbers held data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_result <= '0;
        r_status <= '0;
        r_ext    <= 1'b0;
        r_tag    <= '0;
        r_aux    <= '0;
      end else if (w_ready[i] && w_valid[i]) begin
        r_result <= w_result[i];
        r_status <= w_status[i];
        r_ext    <= w_ext[i];
        r_tag    <= w_tag[i];
        r_aux    <= w_aux[i];
      end
    end

    assign w_valid[i+1]  = r_valid;
    assign w_result[i+1] = r_result;
    assign w_status[i+1] = r_status;
    assign w_ext[i+1]    = r_ext;
    assign w_tag[i+1]    = r_tag;
    assign w_aux[i+1]    = r_aux;
  end

  if (NumPipeRegs > 0) begin : g_occ
    always_comb begin
      w_occ = '0;
      for (int k = 1; k <= NumPipeRegs; k++) begin
        w_occ = w_occ + OccWidth'(w_valid[k]);
      end
    end
  end else begin : g_occ_zero
    logic w_unused_flush;
    assign w_unused_flush = flush_i;
    assign w_occ          = '0;
  end

  assign w_out_hs = w_valid[NumPipeRegs] & out_ready_i;

  // A clear coinciding with a delivery keeps only that delivery's flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fflags <= '0;
    end else if (w_out_hs) begin
      r_fflags <= clr_fflags_i ? w_status[NumPipeRegs] : (r_fflags | w_status[NumPipeRegs]);
    end else if (clr_fflags_i) begin
      r_fflags <= '0;
    end
  end

  assign in_ready_o      = w_ready[0];
  assign result_o        = w_result[NumPipeRegs];
  assign status_o        = w_status[NumPipeRegs];
  assign extension_bit_o = w_ext[NumPipeRegs];
  assign tag_o           = w_tag[NumPipeRegs];
  assign aux_o           = w_aux[NumPipeRegs];
  assign out_valid_o     = w_valid[NumPipeRegs];
  assign fflags_o        = r_fflags;
  assign occupancy_o     = w_occ;
  assign busy_o          = |w_valid;

endmodule

`default_nettype wire

// File: tb/tb_fpnew_pipe_out.sv
// ---------------------------------------------------------------------------
// tb_fpnew_pipe_out : directed bench for a two-stage fpnew_pipe_out
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fpnew_pipe_out;
  import fpnew_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] result_i = '0;
  status_t     status_i = '0;
  logic        extension_bit_i = 1'b0;
  logic [3:0]  tag_i = '0;
  logic        aux_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic        flush_i = 1'b0;
  logic        clr_fflags_i = 1'b0;
  logic [31:0] result_o;
  status_t     status_o;
  logic        extension_bit_o;
  logic [3:0]  tag_o;
  logic        aux_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  status_t     fflags_o;
  logic [1:0]  occupancy_o;
  logic        busy_o;

  int n_total = 0;
  int n_bad   = 0;
  int peak_occ = 0;

  fpnew_pipe_out #(
    .Width      (32),
    .NumPipeRegs(2),
    .TagType    (logic [3:0]),
    .AuxType    (logic)
  ) u_dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .result_i       (result_i),
    .status_i       (status_i),
    .extension_bit_i(extension_bit_i),
    .tag_i          (tag_i),
    .aux_i          (aux_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .flush_i        (flush_i),
    .clr_fflags_i   (clr_fflags_i),
    .result_o       (result_o),
    .status_o       (status_o),
    .extension_bit_o(extension_bit_o),
    .tag_o          (tag_o),
    .aux_o          (aux_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .fflags_o       (fflags_o),
    .occupancy_o    (occupancy_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    if (32'(occupancy_o) > peak_occ) peak_occ = 32'(occupancy_o);
  endtask

  task automatic drive(input logic [31:0] v);
    result_i        = v;
    tag_i           = v[3:0];
    aux_i           = v[0];
    extension_bit_i = v[1];
  endtask

  initial begin
    // reset state
    step(); step();
    check_val("rst_occ",    32'(occupancy_o), 32'd0);
    check_val("rst_result", result_o,         32'd0);
    rst_ni = 1'b1;
    #1;
    check_val("rst_outv",   32'(out_valid_o), 32'd0);
    check_val("rst_fflags", 32'(fflags_o),    32'd0);
    check_val("rst_busy0",  32'(busy_o),      32'd0);

    // streaming, latency 2
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    drive(32'h1);
    #1;
    check_val("rst_busy1", 32'(busy_o), 32'd1);
    peak_occ = 0;
    step(); drive(32'h2);
    check_val("s_outv_c1", 32'(out_valid_o), 32'd0);
    check_val("s_occ_c1",  32'(occupancy_o), 32'd1);
    step(); drive(32'h3);
    check_val("s_outv_c2", 32'(out_valid_o), 32'd1);
    check_val("s_res_c2",  result_o,         32'h1);
    check_val("s_tag_c2",  32'(tag_o),       32'h1);
    check_val("s_aux_c2",  32'(aux_o),       32'h1);
    step(); in_valid_i = 1'b0;
    check_val("s_res_c3",  result_o,         32'h2);
    check_val("s_ext_c3",  32'(extension_bit_o), 32'h1);
    check_val("s_occ_c3",  32'(occupancy_o), 32'd2);
    step();
    check_val("s_res_c4",  result_o,         32'h3);
    check_val("s_occ_c4",  32'(occupancy_o), 32'd1);
    step();
    check_val("s_outv_c5", 32'(out_valid_o), 32'd0);
    check_val("s_peak",    32'(peak_occ),    32'd2);

    // backpressure
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    drive(32'hA);
    #1;
    check_val("bp_rdy0", 32'(in_ready_o), 32'd1);
    step(); drive(32'hB);
    #1;
    check_val("bp_rdy1", 32'(in_ready_o), 32'd1);
    step(); drive(32'hC);
    #1;
    check_val("bp_rdy2", 32'(in_ready_o), 32'd0);
    check_val("bp_out2", result_o,        32'hA);
    step();
    check_val("bp_rdy3",  32'(in_ready_o),  32'd0);
    check_val("bp_out3",  result_o,         32'hA);
    check_val("bp_outv3", 32'(out_valid_o), 32'd1);
    check_val("bp_occ3",  32'(occupancy_o), 32'd2);
    out_ready_i = 1'b1;
    #1;
    check_val("bp_rdy_rel", 32'(in_ready_o), 32'd1);
    step(); in_valid_i = 1'b0;
    check_val("bp_out4", result_o,         32'hB);
    check_val("bp_occ4", 32'(occupancy_o), 32'd2);
    step();
    check_val("bp_out5", result_o,         32'hC);
    check_val("bp_tag5", 32'(tag_o),       32'hC);
    check_val("bp_occ5", 32'(occupancy_o), 32'd1);
    step();
    check_val("bp_outv6", 32'(out_valid_o), 32'd0);

    // bubble collapse
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    drive(32'h51);
    step(); in_valid_i = 1'b0;
    step();
    check_val("bub_occ1", 32'(occupancy_o), 32'd1);
    check_val("bub_outA", result_o,         32'h51);
    in_valid_i = 1'b1;
    drive(32'h52);
    #1;
    check_val("bub_rdyB", 32'(in_ready_o), 32'd1);
    step(); in_valid_i = 1'b0;
    check_val("bub_occ2",  32'(occupancy_o), 32'd2);
    check_val("bub_holdA", result_o,         32'h51);
    out_ready_i = 1'b1;
    step();
    check_val("bub_outB", result_o,         32'h52);
    step();
    check_val("bub_empty", 32'(out_valid_o), 32'd0);

    // flush
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    drive(32'h61);
    step(); drive(32'h62);
    step(); drive(32'h63);
    flush_i = 1'b1;
    step(); flush_i = 1'b0;
    check_val("fl_outv", 32'(out_valid_o), 32'd0);
    check_val("fl_occ",  32'(occupancy_o), 32'd0);
    check_val("fl_busy1", 32'(busy_o),     32'd1);
    in_valid_i = 1'b0;
    #1;
    check_val("fl_busy0", 32'(busy_o), 32'd0);
    step(); step();
    check_val("fl_gone", 32'(out_valid_o), 32'd0);

    // sticky flags
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    drive(32'h71); status_i = 5'b00001;
    step(); drive(32'h72); status_i = 5'b10000;
    step(); in_valid_i = 1'b0; status_i = '0;
    check_val("ff_stat_o", 32'(status_o), 32'h01);
    check_val("ff_pre",    32'(fflags_o), 32'h00);
    step();
    check_val("ff_one", 32'(fflags_o), 32'h01);
    step();
    check_val("ff_or",  32'(fflags_o), 32'h11);
    in_valid_i = 1'b1;
    drive(32'h73); status_i = 5'b00100;
    step(); in_valid_i = 1'b0; status_i = '0;
    step(); clr_fflags_i = 1'b1;
    step(); clr_fflags_i = 1'b0;
    check_val("ff_clr_hs", 32'(fflags_o), 32'h04);
    clr_fflags_i = 1'b1;
    step(); clr_fflags_i = 1'b0;
    check_val("ff_clr", 32'(fflags_o), 32'h00);

    // async reset mid-flight
    in_valid_i = 1'b1;
    drive(32'h81); status_i = 5'b00010;
    step(); in_valid_i = 1'b0; status_i = '0;
    step(); step();
    check_val("ar_ff_pre", 32'(fflags_o), 32'h02);
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    drive(32'h91); status_i = 5'b01000;
    step(); drive(32'h92);
    step(); in_valid_i = 1'b0; status_i = '0;
    check_val("ar_occ_pre", 32'(occupancy_o), 32'd2);
    #1 rst_ni = 1'b0;
    #1;
    check_val("ar_outv",   32'(out_valid_o), 32'd0);
    check_val("ar_occ",    32'(occupancy_o), 32'd0);
    check_val("ar_fflags", 32'(fflags_o),    32'd0);
    check_val("ar_result", result_o,         32'd0);
    check_val("ar_status", 32'(status_o),    32'd0);
    check_val("ar_tag",    32'(tag_o),       32'd0);
    check_val("ar_busy",   32'(busy_o),      32'd0);
    step();
    rst_ni = 1'b1;
    out_ready_i = 1'b1;
    step();
    check_val("ar_after", 32'(out_valid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpnew_pipe_out.md
FPNEW_PIPE_OUT -- requirements
Module: fpnew_pipe_out

Interface
REQ-001 The block SHALL have parameter Width, default 32, giving the result width in bits.
REQ-002 The block SHALL have parameter NumPipeRegs, default 0, giving the number of output register stages.
REQ-003 The block SHALL have parameter TagType, default logic, giving the type of the opaque tag.
REQ-004 The block SHALL have parameter AuxType, default logic, giving the type of the opaque aux field.
REQ-005 The block SHALL have a single clock and an asynchronous active-low reset, as the following two ports.
REQ-006 The block SHALL have port clk_i, input, 1 bit: the clock.
REQ-007 The block SHALL have port rst_ni, input, 1 bit: the asynchronous active-low reset.
REQ-008 The block SHALL have port result_i, input, Width bits: the operation result.
REQ-009 The block SHALL have port status_i, input, fpnew_pkg::status_t (5 bits: NV, DZ, OF, UF, NX): the exception flags.
REQ-010 The block SHALL have port extension_bit_i, input, 1 bit: the NaN-box or sign-extension bit.
REQ-011 The block SHALL have ports tag_i (TagType) and aux_i (AuxType), inputs: sideband carried with the result.
REQ-012 The block SHALL have port in_valid_i, input, 1 bit: upstream valid.
REQ-013 The block SHALL have port in_ready_o, output, 1 bit: upstream ready.
REQ-014 The block SHALL have port flush_i, input, 1 bit: synchronous kill of all in-flight items.
REQ-015 The block SHALL have port clr_fflags_i, input, 1 bit: clears the sticky flag accumulator.
REQ-016 The block SHALL have ports result_o, status_o, extension_bit_o, tag_o and aux_o, outputs, each the same type as its input: the delivered item.
REQ-017 The block SHALL have port out_valid_o, output, 1 bit, and port out_ready_i, input, 1 bit: downstream handshake.
REQ-018 The block SHALL have port fflags_o, output, fpnew_pkg::status_t: sticky OR of the delivered status flags.
REQ-019 The block SHALL have port occupancy_o, output, max(1, $clog2(NumPipeRegs+1)) bits: the number of valid register stages.
REQ-020 The block SHALL have port busy_o, output, 1 bit: high when any valid item is present.

Function
REQ-021 Stage 0 SHALL be the inputs; stage NumPipeRegs SHALL drive the outputs and out_valid_o.
REQ-022 Each stage i SHALL have ready[i] = ready[i+1] | ~valid[i+1], with ready[NumPipeRegs] = out_ready_i and in_ready_o = ready[0].
REQ-023 valid[i+1] SHALL load valid[i] when ready[i] is high, and SHALL hold otherwise.
REQ-024 The data registers of stage i+1 SHALL load only when ready[i] & valid[i] is high, so bubbles never overwrite data.
REQ-025 With no stall, latency SHALL be exactly NumPipeRegs cycles and throughput SHALL be one item per cycle.
REQ-026 A bubble in any stage SHALL be collapsed, so upstream advances while downstream is stalled.
REQ-027 When NumPipeRegs = 0, all data and handshake signals SHALL pass through combinationally and occupancy_o SHALL be 0.
REQ-028 On the clock edge where flush_i is high, all valid registers SHALL clear; the item presented at the input that cycle SHALL be discarded.
REQ-029 A handshake on the output in the flush cycle SHALL still count as delivered.
REQ-030 On each output handshake (out_valid_o & out_ready_i), fflags_o SHALL become fflags_o | status_o on the next edge.
REQ-031 When clr_fflags_i is high with no output handshake, fflags_o SHALL become 0 on the next edge.
REQ-032 When clr_fflags_i and an output handshake coincide, fflags_o SHALL become exactly status_o of that handshake.
REQ-033 flush_i SHALL NOT affect fflags_o.
REQ-034 occupancy_o SHALL be the popcount of valid[1..NumPipeRegs], registered-accurate each cycle, and SHALL never exceed NumPipeRegs.
REQ-035 busy_o SHALL be the OR of valid[0..NumPipeRegs], with valid[0] = in_valid_i.
REQ-036 Output data SHALL hold stable while out_valid_o is high and out_ready_i is low.

Reset
REQ-037 While rst_ni is low, all valid registers, fflags_o and occupancy_o SHALL be 0, asynchronously.
REQ-038 While rst_ni is low, all data registers SHALL be 0.
REQ-039 After reset, out_valid_o SHALL be 0, and busy_o SHALL equal in_valid_i.
REQ-040 Reset asserted mid-operation SHALL drop all in-flight items without any output handshake.

Verification
REQ-041 With NumPipeRegs=2 and out_ready_i=1, the bench SHALL drive results 0x1,0x2,0x3 on consecutive cycles and check they appear on cycles 2,3,4 in order, with occupancy_o peaking at 2.
REQ-042 With NumPipeRegs=2 and out_ready_i=0, the bench SHALL drive 3 items and check that in_ready_o falls after 2 are accepted, the third is held upstream, out_ready_i=1 drains all 3 in order, and none are lost or duplicated.
REQ-043 With NumPipeRegs=2, the bench SHALL insert a bubble after item A, stall downstream, send item B, and check B advances into the bubble slot and occupancy_o=2.
REQ-044 With NumPipeRegs=2 holding 2 items and a third presented, the bench SHALL pulse flush_i and check that on the next cycle out_valid_o=0, occupancy_o=0 and busy_o=in_valid_i.
REQ-045 The bench SHALL deliver status 5'b00001 then 5'b10000 and check fflags_o=5'b10001, then deliver 5'b00100 together with clr_fflags_i and check fflags_o=5'b00100.
REQ-046 The bench SHALL assert rst_ni low with 2 items in flight and check all outputs of REQ-037 and REQ-038 go 0 immediately, before the next clock edge.
